// File: rtl/i2s_pair_fifo.sv
// i2s_pair_fifo: pairs I2S left/right words into stereo frames with a mono average, buffered in a FWFT FIFO
module i2s_pair_fifo #(
    parameter int DEPTH   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_lrc,
    input  logic [DEPTH-1:0]   i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [DEPTH-1:0]   o_left,
    output logic [DEPTH-1:0]   o_right,
    output logic [DEPTH-1:0]   o_mono,
    output logic [FIFO_AW:0]   o_level,
    output logic [15:0]        o_ovf_cnt,
    output logic               o_sync_err
);
    localparam int N = 2 ** FIFO_AW;

    typedef enum logic {WAIT_L, HAVE_L} state_t;

    state_t               state_q, state_d;
    logic [DEPTH-1:0]     left_q, left_d;
    logic [FIFO_AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [15:0]          ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic [3*DEPTH-1:0]   mem_q [N];
    logic [3*DEPTH-1:0]   head;
    logic                 done, latch_l, push, bad, pop, full, wr_en, drop;
    logic [DEPTH:0]       sum;
    logic [DEPTH-1:0]     mono;

    // a disabled block ignores incoming words entirely
    assign done  = i_rx_done && i_en;
    assign pop   = o_valid && i_ready;
    assign full  = level_q == (FIFO_AW+1)'(N);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign sum   = {left_q[DEPTH-1], left_q} + {i_rx_data[DEPTH-1], i_rx_data};
    assign mono  = DEPTH'(sum >> 1);

    // pairing state register
    always_ff @(posedge clk_50m) begin
        if (!rst_n) state_q <= WAIT_L;
        else        state_q <= state_d;
    end

    // pairing next state: any left word leads to HAVE_L, any right word back to WAIT_L
    always_comb begin
        state_d = !i_en ? WAIT_L : done ? (i_lrc ? WAIT_L : HAVE_L) : state_q;
    end

    // pairing outputs: latch left, complete a frame, or flag an out-of-order channel
    always_comb begin
        latch_l = done && !i_lrc;
        push    = done && i_lrc && state_q == HAVE_L;
        bad     = done && (i_lrc == (state_q == WAIT_L));
    end

    // FIFO pointer, level and diagnostic next-state
    always_comb begin
        left_d  = latch_l ? i_rx_data : left_q;
        wr_d    = !i_en ? '0 : wr_q + FIFO_AW'(wr_en);
        rd_d    = !i_en ? '0 : rd_q + FIFO_AW'(pop);
        level_d = !i_en ? '0 : level_q + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);
        ovf_d   = (drop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
        err_d   = i_en && (err_q || bad);
    end

    // datapath registers with reset
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            left_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            left_q  <= left_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // frame storage; contents need no reset since the level gates visibility
    always_ff @(posedge clk_50m) begin
        if (wr_en) mem_q[wr_q] <= {mono, left_q, i_rx_data};
    end

    assign head       = mem_q[rd_q];
    assign o_valid    = level_q != '0;
    assign o_mono     = o_valid ? head[3*DEPTH-1 -: DEPTH] : '0;
    assign o_left     = o_valid ? head[2*DEPTH-1 -: DEPTH] : '0;
    assign o_right    = o_valid ? head[DEPTH-1:0] : '0;
    assign o_level    = level_q;
    assign o_ovf_cnt  = ovf_q;
    assign o_sync_err = err_q;
endmodule

// File: tb/tb_i2s_pair_fifo.sv
// tb_i2s_pair_fifo: table vectors plus scoreboarded corner sequences for i2s_pair_fifo
module tb_i2s_pair_fifo;
    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0, i_en = 1'b0, i_lrc = 1'b0, i_rx_done = 1'b0, i_ready = 1'b0;
    logic [15:0] i_rx_data = '0;
    logic        o_valid, o_sync_err;
    logic [15:0] o_left, o_right, o_mono, o_ovf_cnt;
    logic [4:0]  o_level;

    always #10 clk_50m = ~clk_50m;

    i2s_pair_fifo #(.DEPTH(16), .FIFO_AW(4)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .i_en(i_en), .i_lrc(i_lrc),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_ready(i_ready),
        .o_valid(o_valid), .o_left(o_left), .o_right(o_right), .o_mono(o_mono),
        .o_level(o_level), .o_ovf_cnt(o_ovf_cnt), .o_sync_err(o_sync_err)
    );

    typedef struct {logic [15:0] l; logic [15:0] r; logic [15:0] m;} vec_t;

    vec_t        tbl [5];
    vec_t        sb [$];
    vec_t        e;
    int          checks = 0, errors = 0, exp_ovf = 0;
    bit          mon_on = 0, hl = 0, exp_err = 0;
    logic [15:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mono_of(input logic [15:0] l, input logic [15:0] r);
        logic signed [16:0] s;
        s = $signed({l[15], l}) + $signed({r[15], r});
        return s[16:1];
    endfunction

    task automatic tick;
        @(posedge clk_50m);
        #1;
    endtask

    // drive one word and advance the reference pairing model after the edge
    task automatic send_word(input logic lrc, input logic [15:0] d);
        bit drop;
        drop = hl && lrc && sb.size() == 16 && !i_ready;
        i_lrc = lrc;
        i_rx_data = d;
        i_rx_done = 1'b1;
        tick;
        i_rx_done = 1'b0;
        if (!hl && lrc) exp_err = 1;
        else if (!hl) begin held = d; hl = 1; end
        else if (!lrc) begin held = d; exp_err = 1; end
        else begin
            hl = 0;
            if (drop) exp_ovf = (exp_ovf == 65535) ? exp_ovf : exp_ovf + 1;
            else sb.push_back('{l: held, r: d, m: mono_of(held, d)});
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_word(1'b0, l);
        send_word(1'b1, r);
    endtask

    task automatic fill(input int n, input int seed);
        for (int k = 0; k < n; k++) send_frame(16'((seed + k) * 257), 16'(16'hF000 - seed - k));
    endtask

    task automatic drain;
        i_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick;
        i_ready = 1'b0;
        chk("drain_complete", sb.size() == 0, 1);
    endtask

    task automatic flush;
        i_en = 1'b0;
        tick;
        i_en = 1'b1;
        sb.delete();
        hl = 0;
        exp_err = 0;
    endtask

    // every active cycle: compare status against the model, and pop the scoreboard on a handshake
    always @(negedge clk_50m) begin
        if (mon_on && rst_n && i_en) begin
            chk("valid", o_valid, sb.size() != 0);
            chk("level", o_level, sb.size());
            chk("ovf_cnt", o_ovf_cnt, exp_ovf);
            chk("sync_err", o_sync_err, exp_err);
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got frame %0h/%0h want none", o_left, o_right);
                end else begin
                    e = sb.pop_front();
                    chk("pop_left", o_left, e.l);
                    chk("pop_right", o_right, e.r);
                    chk("pop_mono", o_mono, e.m);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{l: 16'h1234, r: 16'h0100, m: 16'h099A};
        tbl[1] = '{l: 16'h7FFF, r: 16'h7FFF, m: 16'h7FFF};
        tbl[2] = '{l: 16'h8000, r: 16'h8000, m: 16'h8000};
        tbl[3] = '{l: 16'h0001, r: 16'hFFFF, m: 16'h0000};
        tbl[4] = '{l: 16'hFFFF, r: 16'hFFFE, m: 16'hFFFE};

        i_en = 1'b1;
        tick;
        tick;
        chk("rst_valid", o_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ovf", o_ovf_cnt, 0);
        chk("rst_err", o_sync_err, 0);
        chk("rst_left", o_left, 0);
        chk("rst_mono", o_mono, 0);
        rst_n = 1'b1;
        mon_on = 1;
        tick;

        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].l, tbl[i].r);
            chk("tbl_valid", o_valid, 1);
            chk("tbl_level", o_level, 1);
            chk("tbl_left", o_left, tbl[i].l);
            chk("tbl_right", o_right, tbl[i].r);
            chk("tbl_mono", o_mono, tbl[i].m);
            i_ready = 1'b1;
            tick;
            i_ready = 1'b0;
            chk("tbl_popped", o_valid, 0);
        end

        fill(18, 1);
        chk("ovf_level", o_level, 16);
        chk("ovf_cnt2", o_ovf_cnt, 2);
        drain;
        chk("ovf_drained", o_level, 0);

        fill(16, 40);
        send_word(1'b0, 16'h2222);
        i_ready = 1'b1;
        send_word(1'b1, 16'h3333);
        i_ready = 1'b0;
        chk("fullpop_level", o_level, 16);
        chk("fullpop_ovf", o_ovf_cnt, 2);
        drain;

        send_word(1'b1, 16'hAAAA);
        send_word(1'b0, 16'h0BBB);
        send_word(1'b1, 16'h0CCC);
        chk("syncR_err", o_sync_err, 1);
        chk("syncR_level", o_level, 1);
        chk("syncR_left", o_left, 16'h0BBB);
        chk("syncR_right", o_right, 16'h0CCC);
        drain;
        flush;
        chk("flush1_err", o_sync_err, 0);

        send_word(1'b0, 16'h0011);
        send_word(1'b0, 16'h0022);
        send_word(1'b1, 16'h0033);
        chk("syncL_err", o_sync_err, 1);
        chk("syncL_left", o_left, 16'h0022);
        fill(4, 70);
        send_word(1'b0, 16'h4444);
        chk("preflush_level", o_level, 5);
        flush;
        chk("flush_level", o_level, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_err", o_sync_err, 0);
        chk("flush_ovf", o_ovf_cnt, 2);
        send_word(1'b1, 16'h5555);
        chk("fresh_R_err", o_sync_err, 1);
        flush;

        fill(17, 100);
        i_ready = 1'b1;
        repeat (7) tick;
        i_ready = 1'b0;
        chk("prerst_level", o_level, 9);
        chk("prerst_ovf", o_ovf_cnt, 3);
        send_word(1'b0, 16'h6666);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        sb.delete();
        hl = 0;
        exp_err = 0;
        exp_ovf = 0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_level", o_level, 0);
        chk("midrst_ovf", o_ovf_cnt, 0);
        chk("midrst_err", o_sync_err, 0);
        chk("midrst_right", o_right, 0);
        send_frame(16'h4000, 16'hC000);
        chk("post_valid", o_valid, 1);
        chk("post_level", o_level, 1);
        chk("post_left", o_left, 16'h4000);
        chk("post_right", o_right, 16'hC000);
        chk("post_mono", o_mono, 16'h0000);
        chk("post_err", o_sync_err, 0);
        drain;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_pair_fifo.md
Name: i2s_pair_fifo

Overview:
- Sits directly downstream of the I2S ADC receiver.
- Consumes its per-half-frame sample word and 1-clk done pulse, tags each word as left or right from the LRCLK level, and pairs them into stereo frames.
- Computes a mono average per frame and buffers frames in a small synchronous FIFO.
- Presents frames to the spectrum datapath over a valid/ready handshake, with overflow and channel-sync diagnostics.

Parameters:
- DEPTH, 16, sample width in bits (must match receiver).
- FIFO_AW, 4, FIFO address width; capacity = 2**FIFO_AW frames (16).

Ports:
- clk_50m  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- i_en  input  1  enable; low = synchronous flush.
- i_lrc  input  1  ADC LRCLK level (0 = left, 1 = right).
- i_rx_data  input  DEPTH  received sample, two's complement.
- i_rx_done  input  1  1-clk strobe; i_rx_data valid this cycle.
- i_ready  input  1  consumer ready.
- o_valid  output  1  FIFO head frame available.
- o_left  output  DEPTH  head left sample.
- o_right  output  DEPTH  head right sample.
- o_mono  output  DEPTH  head mono sample, floor((L+R)/2).
- o_level  output  FIFO_AW+1  frames currently stored.
- o_ovf_cnt  output  16  frames dropped because FIFO full; saturating.
- o_sync_err  output  1  sticky channel-pairing error.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - o_valid=0, o_level=0, o_ovf_cnt=0, o_sync_err=0.
  - Pairing state = WAIT_L; held left register = 0; FIFO pointers = 0.
  - o_left/o_right/o_mono = 0 while empty.
- Channel tag: sampled from i_lrc in the same cycle as i_rx_done.
- Pairing FSM:
  - WAIT_L + done, lrc=0: latch left, go to HAVE_L.
  - WAIT_L + done, lrc=1: discard word, set o_sync_err, stay in WAIT_L.
  - HAVE_L + done, lrc=0: overwrite held left, set o_sync_err, stay in HAVE_L.
  - HAVE_L + done, lrc=1: frame complete; push {mono, left, right}; go to WAIT_L.
  - No done: hold state.
- Mono arithmetic:
  - sum = sign-extend(L) + sign-extend(R), DEPTH+1 bits.
  - mono = sum[DEPTH:1] (arithmetic shift right, floor toward -inf); no overflow possible.
  - Computed at push time and stored in the FIFO.
- FIFO: memory width 3*DEPTH, first-word-fall-through.
  - Head fields drive o_left/o_right/o_mono directly from memory at the read pointer.
  - o_valid = (o_level != 0).
  - Push at the clock edge of the frame-complete cycle; o_valid rises the following cycle (1-clk latency done->valid).
  - Pop occurs when o_valid && i_ready at a clock edge; head advances the next cycle.
  - Pointers are FIFO_AW bits and wrap modulo 2**FIFO_AW; o_level counts 0..2**FIFO_AW.
- Full (o_level = 2**FIFO_AW):
  - Push without pop in the same cycle: frame dropped, o_ovf_cnt += 1, saturating at 0xFFFF; FSM still returns to WAIT_L.
  - Push with pop in the same cycle: both proceed; level unchanged; no drop.
- Empty: pop is impossible (o_valid=0); i_ready ignored.
- Push and pop in the same cycle at any level between empty and full: level unchanged.
- i_en=0 (synchronous, every cycle it is low):
  - FIFO pointers and level cleared; FSM to WAIT_L; o_sync_err cleared.
  - o_ovf_cnt retained.
  - i_rx_done ignored.
  - Outputs behave as empty from the next cycle.
- i_en rising: pairing starts fresh in WAIT_L, so a leading right word sets o_sync_err.
- Reset mid-operation: all state discarded per the reset values; no partial frame survives.
- Input constraints: i_rx_done is single-cycle and at least DEPTH BCLK periods apart; the block does not check this.

Test Plan:
- Frame push and mono: i_en=1, done lrc=0 data 0x1234, then done lrc=1 data 0x0100 -> one cycle later o_valid=1, o_left=0x1234, o_right=0x0100, o_mono=0x099A, o_level=1; i_ready=1 for one cycle -> o_valid=0.
- Mono rounding (one frame each, sequence L/R -> mono):
  - 0x7FFF/0x7FFF -> 0x7FFF
  - 0x8000/0x8000 -> 0x8000
  - 0x0001/0xFFFF -> 0x0000
  - 0xFFFF/0xFFFE -> 0xFFFE
- Overflow: i_ready=0, push 18 frames -> o_level=16, o_ovf_cnt=2; drain with i_ready=1 -> first 16 frames emerge in order, o_level reaches 0. Second case: fill to 16, then complete a frame in the same cycle as a pop -> o_ovf_cnt unchanged, level stays 16.
- Sync errors:
  - Sequence R, L, R -> o_sync_err=1, exactly one frame pushed, containing the second-word L and the third-word R.
  - Sequence L(0x0011), L(0x0022), R -> o_sync_err=1, pushed frame left=0x0022.
- Flush: with 5 frames stored and FSM in HAVE_L, pulse i_en=0 for 1 clk -> next cycle o_level=0, o_valid=0, o_sync_err=0, o_ovf_cnt unchanged; a following R word sets o_sync_err.
- Reset mid-stream: assert rst_n=0 with FIFO at level 9 and o_ovf_cnt=3 -> after the edge, all outputs zero and state WAIT_L; a normal L/R pair then yields one valid frame.
